// File: rtl/layer_output_serializer.sv
// ---------------------------------------------------------------------------
// layer_output_serializer
//
// Collects NUM_NEURONS parallel neuron results and streams them out one word
// per cycle, starting with neuron 0. Each result arrives with its own 1-cycle
// valid pulse, in any order and in any cycle. A capture bank gathers the
// results. A separate shift bank streams them. This lets the producing layer
// fill the next set while the previous set is still being serialized.
//
// Optional feature macro: LAYER_SER_MAXIDX_EN
//   When it is defined, the signed argmax of each transferred set is registered
//   onto max_idx, and max_valid pulses together with word 0.
//   When it is undefined, max_idx and max_valid are tied to 0.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   x_in       neuron outputs, neuron i in [i*DATA_WIDTH +: DATA_WIDTH]
//   x_valid    per-neuron 1-cycle valid, bit i qualifies slice i
//   y_out      serialized word (to next layer myinput)
//   y_valid    y_out valid (to next layer myinputValid)
//   y_last     high with y_valid on word NUM_NEURONS-1
//   y_idx      index of the word on y_out
//   busy       shift bank streaming or a complete set waiting
//   overrun    sticky: a result was dropped because its slot was full
//   max_idx    argmax of the last transferred set (feature only)
//   max_valid  1-cycle pulse when max_idx updates (feature only)
// ---------------------------------------------------------------------------
module layer_output_serializer #(
  parameter int NUM_NEURONS = 5,
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_WIDTH   = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] x_in,
  input  logic [NUM_NEURONS-1:0]            x_valid,
  output logic [DATA_WIDTH-1:0]             y_out,
  output logic                              y_valid,
  output logic                              y_last,
  output logic [IDX_WIDTH-1:0]              y_idx,
  output logic                              busy,
  output logic                              overrun,
  output logic [IDX_WIDTH-1:0]              max_idx,
  output logic                              max_valid
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state_r, state_s;

  logic [NUM_NEURONS-1:0] flag_r;
  logic [DATA_WIDTH-1:0]  cap_r [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]  cap_s [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]  sh_r  [NUM_NEURONS];
  logic [IDX_WIDTH-1:0]   k_r;
  logic [IDX_WIDTH-1:0]   k_nx_s;
  logic [NUM_NEURONS-1:0] refill_s;
  logic                   complete_s;
  logic                   at_last_s;
  logic                   transfer_s;

  // Capture bank as it would look after this edge (an empty slot takes its new
  // value). The set counts as complete as soon as the final missing result
  // arrives. This gives word 0 on the very next cycle.
  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (x_valid[i] && !flag_r[i]) begin
        cap_s[i] = x_in[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        cap_s[i] = cap_r[i];
      end
    end
    complete_s = &(flag_r | x_valid);
    at_last_s  = (k_r == LAST_IDX);
    k_nx_s     = k_r + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
    // A valid on an already-full slot either starts the next set (on a
    // transfer edge) or is dropped as an overrun.
    refill_s   = x_valid & flag_r;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and the transfer decision. A complete set moves to the
  // shift bank when idle, or right after the last word so sets run gap-free.
  always_comb begin
    state_s    = state_r;
    transfer_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (complete_s) begin
          transfer_s = 1'b1;
          state_s    = SHIFT;
        end else begin
          state_s    = IDLE;
        end
      end
      SHIFT: begin
        if (at_last_s) begin
          if (complete_s) begin
            transfer_s = 1'b1;
            state_s    = SHIFT;
          end else begin
            state_s    = IDLE;
          end
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Capture bank, slot flags and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_r  <= {NUM_NEURONS{1'b0}};
      overrun <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cap_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (transfer_s) begin
      // The bank empties. Refill valids on this edge seed the fresh set.
      flag_r <= refill_s;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (refill_s[i]) begin
          cap_r[i] <= x_in[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          cap_r[i] <= cap_r[i];
        end
      end
    end else begin
      flag_r <= flag_r | x_valid;
      cap_r  <= cap_s;
      if (|refill_s) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
    end
  end

  // Shift bank and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r     <= {IDX_WIDTH{1'b0}};
      y_out   <= {DATA_WIDTH{1'b0}};
      y_valid <= 1'b0;
      y_last  <= 1'b0;
      y_idx   <= {IDX_WIDTH{1'b0}};
      busy    <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        sh_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (transfer_s) begin
      sh_r    <= cap_s;
      k_r     <= {IDX_WIDTH{1'b0}};
      y_out   <= cap_s[0];
      y_valid <= 1'b1;
      y_last  <= 1'b0;
      y_idx   <= {IDX_WIDTH{1'b0}};
      busy    <= 1'b1;
    end else if (state_r == SHIFT && !at_last_s) begin
      k_r     <= k_nx_s;
      y_out   <= sh_r[k_nx_s];
      y_valid <= 1'b1;
      y_last  <= (k_nx_s == LAST_IDX);
      y_idx   <= k_nx_s;
      busy    <= 1'b1;
    end else if (state_r == SHIFT) begin
      // Last word went out and nothing is pending.
      y_valid <= 1'b0;
      y_last  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      y_last  <= 1'b0;
      busy    <= 1'b0;
    end
  end

`ifdef LAYER_SER_MAXIDX_EN
  logic [DATA_WIDTH-1:0] best_val_s;
  logic [IDX_WIDTH-1:0]  best_idx_s;

  // Signed argmax over the set being transferred. The strict compare keeps
  // the lowest index on ties.
  always_comb begin
    best_val_s = cap_s[0];
    best_idx_s = {IDX_WIDTH{1'b0}};
    for (int i = 1; i < NUM_NEURONS; i++) begin
      if ($signed(cap_s[i]) > $signed(best_val_s)) begin
        best_val_s = cap_s[i];
        best_idx_s = IDX_WIDTH'(i);
      end else begin
        best_val_s = best_val_s;
      end
    end
  end

  // Registered class output. It pulses alongside word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_idx   <= {IDX_WIDTH{1'b0}};
      max_valid <= 1'b0;
    end else if (transfer_s) begin
      max_idx   <= best_idx_s;
      max_valid <= 1'b1;
    end else begin
      max_idx   <= max_idx;
      max_valid <= 1'b0;
    end
  end
`else
  assign max_idx   = {IDX_WIDTH{1'b0}};
  assign max_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_output_serializer.sv
module tb_layer_output_serializer;

  localparam int N  = 5;
  localparam int DW = 16;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] x_in;
  logic [N-1:0]    x_valid;
  logic [DW-1:0]   y_out;
  logic            y_valid;
  logic            y_last;
  logic [IW-1:0]   y_idx;
  logic            busy;
  logic            overrun;
  logic [IW-1:0]   max_idx;
  logic            max_valid;

  int checks   = 0;
  int failures = 0;

  // Each entry is {data, idx, last}.
  logic [DW+IW:0] sb_q [$];

  layer_output_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid),
    .y_out(y_out), .y_valid(y_valid), .y_last(y_last), .y_idx(y_idx),
    .busy(busy), .overrun(overrun), .max_idx(max_idx), .max_valid(max_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pack5(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                            input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                                            input logic [DW-1:0] w4);
    return {w4, w3, w2, w1, w0};
  endfunction

  task automatic push_set(input logic [N*DW-1:0] d);
    for (int i = 0; i < N; i++) begin
      sb_q.push_back({d[i*DW +: DW], IW'(i), (i == N-1)});
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d);
    @(negedge clk);
    x_valid = v;
    x_in    = d;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      x_valid = '0;
    end
  endtask

  // Output monitor: every valid word must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [DW+IW:0] e;
    if (y_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_word", {16'h0, y_out}, 32'hFFFFFFFF);
      end else begin
        e = sb_q.pop_front();
        check_eq("word_data", {16'h0, y_out}, {16'h0, e[DW+IW:IW+1]});
        check_eq("word_idx",  {29'h0, y_idx}, {29'h0, e[IW:1]});
        check_eq("word_last", {31'h0, y_last}, {31'h0, e[0]});
      end
    end
  end

  logic [N*DW-1:0] set_a, set_b, v;
  logic [0:0] exp_mv;

  initial begin
    rst = 1'b1; x_valid = '0; x_in = '0;
    quiet(3);
    check_eq("rst_y_out",     {16'h0, y_out}, 32'h0);
    check_eq("rst_y_valid",   {31'h0, y_valid}, 32'h0);
    check_eq("rst_y_last",    {31'h0, y_last}, 32'h0);
    check_eq("rst_y_idx",     {29'h0, y_idx}, 32'h0);
    check_eq("rst_busy",      {31'h0, busy}, 32'h0);
    check_eq("rst_overrun",   {31'h0, overrun}, 32'h0);
    check_eq("rst_max_idx",   {29'h0, max_idx}, 32'h0);
    check_eq("rst_max_valid", {31'h0, max_valid}, 32'h0);
    rst = 1'b0;
    quiet(2);

    // All five valids in one cycle.
    set_a = pack5(16'h0CCC, 16'hE666, 16'h2666, 16'hCCCC, 16'h4000);
    push_set(set_a);
    drive(5'h1F, set_a);
    quiet(1);
    check_eq("t1_first_valid", {31'h0, y_valid}, 32'h1);
    check_eq("t1_busy", {31'h0, busy}, 32'h1);
    quiet(4);
    check_eq("t1_last_still_valid", {31'h0, y_valid}, 32'h1);
    quiet(1);
    check_eq("t1_valid_end", {31'h0, y_valid}, 32'h0);
    check_eq("t1_busy_end", {31'h0, busy}, 32'h0);
    check_eq("t1_overrun", {31'h0, overrun}, 32'h0);

    // Staggered valids: bit 4, then bit 0, then bits 1-3.
    set_a = pack5(16'h0101, 16'h8202, 16'h0303, 16'h7FFF, 16'h8000);
    push_set(set_a);
    drive(5'b10000, set_a);
    quiet(1);
    drive(5'b00001, set_a);
    quiet(1);
    check_eq("t2_no_early", {31'h0, y_valid}, 32'h0);
    drive(5'b01110, set_a);
    quiet(1);
    check_eq("t2_first_valid", {31'h0, y_valid}, 32'h1);
    quiet(5);
    check_eq("t2_valid_end", {31'h0, y_valid}, 32'h0);

    // Back-to-back: set B completes while set A streams, ten contiguous words.
    set_a = pack5(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000);
    set_b = pack5(16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005);
    push_set(set_a);
    push_set(set_b);
    drive(5'h1F, set_a);
    for (int j = 0; j < 10; j++) begin
      if (j == 2) drive(5'h1F, set_b);
      else quiet(1);
      check_eq("t3_contiguous", {31'h0, y_valid}, 32'h1);
    end
    quiet(1);
    check_eq("t3_valid_end", {31'h0, y_valid}, 32'h0);
    check_eq("t3_overrun", {31'h0, overrun}, 32'h0);

    // Overrun: slot 2 written twice, the first value must survive.
    drive(5'b00100, pack5(16'h0, 16'h0, 16'h1111, 16'h0, 16'h0));
    quiet(1);
    drive(5'b00100, pack5(16'h0, 16'h0, 16'h2222, 16'h0, 16'h0));
    quiet(1);
    check_eq("t4_overrun", {31'h0, overrun}, 32'h1);
    check_eq("t4_not_complete", {31'h0, y_valid}, 32'h0);
    v = pack5(16'h0A0A, 16'h0B0B, 16'h3333, 16'h0D0D, 16'h0E0E);
    push_set(pack5(16'h0A0A, 16'h0B0B, 16'h1111, 16'h0D0D, 16'h0E0E));
    drive(5'b11011, v);
    quiet(6);
    check_eq("t4_overrun_sticky", {31'h0, overrun}, 32'h1);

    // Reset mid-stream with a partial next set already captured.
    set_a = pack5(16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999);
    push_set(set_a);
    drive(5'h1F, set_a);
    quiet(1);
    drive(5'b00011, pack5(16'hDEAD, 16'hBEEF, 16'h0, 16'h0, 16'h0));
    quiet(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_valid_after_rst", {31'h0, y_valid}, 32'h0);
    check_eq("t5_busy_after_rst", {31'h0, busy}, 32'h0);
    check_eq("t5_overrun_cleared", {31'h0, overrun}, 32'h0);
    sb_q.delete();
    set_b = pack5(16'h0F01, 16'h0F02, 16'h0F03, 16'h0F04, 16'h0F05);
    drive(5'b11100, set_b);
    quiet(2);
    check_eq("t5_flags_cleared", {31'h0, y_valid}, 32'h0);
    push_set(set_b);
    drive(5'b00011, set_b);
    quiet(1);
    check_eq("t5_restream", {31'h0, y_valid}, 32'h1);
    quiet(5);

    // Argmax: values tie at slots 2 and 4, so the lowest index (2) wins.
    set_a = pack5(16'h0CCC, 16'hE666, 16'h4000, 16'hCCCC, 16'h4000);
    push_set(set_a);
    drive(5'h1F, set_a);
    quiet(1);
`ifdef LAYER_SER_MAXIDX_EN
    exp_mv = 1'b1;
    check_eq("t6_max_idx", {29'h0, max_idx}, 32'h2);
`else
    exp_mv = 1'b0;
    check_eq("t6_max_idx_tied", {29'h0, max_idx}, 32'h0);
`endif
    check_eq("t6_max_valid_word0", {31'h0, max_valid}, {31'h0, exp_mv});
    quiet(1);
    check_eq("t6_max_valid_pulse", {31'h0, max_valid}, 32'h0);
    quiet(5);

    check_eq("sb_drained", sb_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
